// File: rtl/int2fp.sv
// int2fp: pipelined signed fixed-point to floating-point converter.
//
// Converts a two's-complement sample with R fractional bits into a
// {sign, exponent, mantissa} word (I_EXP exponent bits, I_MNT stored
// mantissa bits, hidden leading one). Rounding is round-to-nearest,
// ties-to-even. Results too small to represent become signed zero, and
// results too large become signed infinity. No subnormals and no NaNs
// are produced. The word width I_DATA must equal 1 + I_EXP + I_MNT.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-low reset (0 = reset)
//   enable    input-valid qualifier for int_in
//   int_in    signed fixed-point sample, value = int_in / 2^R
//   fp_out    {sign, exponent[I_EXP-1:0], mantissa[I_MNT-1:0]}
//   out_valid fp_out holds a valid conversion (3 cycles after enable)
module int2fp #(
  parameter int I_EXP  = 5,
  parameter int I_MNT  = 10,
  parameter int I_DATA = 16,
  parameter int R      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [I_DATA-1:0] int_in,
  output logic [I_DATA-1:0] fp_out,
  output logic              out_valid
);

  localparam int BIAS = (1 << (I_EXP - 1)) - 1;
  localparam int EMAX = (1 << I_EXP) - 1;
  localparam int PW   = $clog2(I_DATA);

  // Magnitude as an unsigned word; the most negative input maps to
  // 2^(I_DATA-1), which still fits.
  function automatic logic [I_DATA-1:0] abs_mag(input logic signed [I_DATA-1:0] x);
    logic signed [I_DATA-1:0] neg;
    neg = -x;
    return x[I_DATA-1] ? $unsigned(neg) : $unsigned(x);
  endfunction

  function automatic logic [PW-1:0] leading_one(input logic [I_DATA-1:0] m);
    logic [PW-1:0] pos;
    pos = '0;
    for (int i = 0; i < I_DATA; i++) begin
      if (m[i]) pos = PW'(i);
    end
    return pos;
  endfunction

  // norm holds the normalized magnitude with its leading one removed:
  // the top I_MNT bits are the mantissa, the next is the guard bit and
  // everything below is folded into sticky.
  function automatic logic [I_DATA-1:0] round_pack(
    input logic              s,
    input logic              z,
    input logic [I_DATA-2:0] norm,
    input logic [PW-1:0]     pos
  );
    logic [I_MNT-1:0] mant;
    logic             guard;
    logic             sticky;
    logic             inc;
    logic [I_MNT:0]   mant_r;
    int               exp_b;
    mant   = norm[I_DATA-2 -: I_MNT];
    guard  = norm[I_EXP-1];
    sticky = |norm[I_EXP-2:0];
    inc    = guard & (sticky | mant[0]);
    mant_r = {1'b0, mant} + {{I_MNT{1'b0}}, inc};
    exp_b  = int'(pos) - R + BIAS;
    // Carry out of the mantissa leaves mant_r[I_MNT-1:0] all zero,
    // which is exactly the mantissa of the next binade.
    if (mant_r[I_MNT]) exp_b = exp_b + 1;
    if (z)
      return '0;
    else if (exp_b <= 0)
      return {s, {(I_DATA-1){1'b0}}};
    else if (exp_b >= EMAX)
      return {s, {I_EXP{1'b1}}, {I_MNT{1'b0}}};
    else
      return {s, exp_b[I_EXP-1:0], mant_r[I_MNT-1:0]};
  endfunction

  logic signed [I_DATA-1:0] in_s;

  logic                     sign_p0;
  logic        [I_DATA-1:0] mag_p0;
  logic                     vld_p0;

  logic                     sign_p1;
  logic                     zero_p1;
  logic        [I_DATA-2:0] norm_p1;
  logic        [PW-1:0]     pos_p1;
  logic                     vld_p1;

  logic        [I_DATA-1:0] fp_p2;
  logic                     vld_p2;

  logic        [PW-1:0]     lead_pos;
  logic        [PW-1:0]     sh_amt;
  logic        [I_DATA-1:0] norm_c;

  assign in_s     = int_in;
  assign lead_pos = leading_one(mag_p0);
  assign sh_amt   = PW'(I_DATA - 1) - lead_pos;
  assign norm_c   = mag_p0 << sh_amt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sign_p0 <= 1'b0;
      mag_p0  <= '0;
      vld_p0  <= 1'b0;
      sign_p1 <= 1'b0;
      zero_p1 <= 1'b0;
      norm_p1 <= '0;
      pos_p1  <= '0;
      vld_p1  <= 1'b0;
      fp_p2   <= '0;
      vld_p2  <= 1'b0;
    end else begin
      // Stage 1: sign / magnitude
      sign_p0 <= in_s[I_DATA-1];
      mag_p0  <= abs_mag(in_s);
      vld_p0  <= enable;
      // Stage 2: normalize; after the shift the MSB is set unless the
      // magnitude was zero, so it doubles as the zero flag.
      sign_p1 <= sign_p0;
      zero_p1 <= ~norm_c[I_DATA-1];
      norm_p1 <= norm_c[I_DATA-2:0];
      pos_p1  <= lead_pos;
      vld_p1  <= vld_p0;
      // Stage 3: round and pack
      fp_p2   <= round_pack(sign_p1, zero_p1, norm_p1, pos_p1);
      vld_p2  <= vld_p1;
    end
  end

  assign fp_out    = fp_p2;
  assign out_valid = vld_p2;

endmodule

// File: tb/tb_int2fp.sv
// Self-checking bench for int2fp with a reference model that works on
// integer values (log2, divide and remainder) instead of bit slicing.
module tb_int2fp;

  localparam int I_EXP  = 5;
  localparam int I_MNT  = 10;
  localparam int I_DATA = 16;
  localparam int R      = 8;
  localparam int BIAS   = (1 << (I_EXP - 1)) - 1;

  logic              clk;
  logic              reset;
  logic              enable;
  logic [I_DATA-1:0] int_in;
  logic [I_DATA-1:0] fp_out;
  logic              out_valid;

  int2fp #(.I_EXP(I_EXP), .I_MNT(I_MNT), .I_DATA(I_DATA), .R(R)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .int_in    (int_in),
    .fp_out    (fp_out),
    .out_valid (out_valid)
  );

  typedef struct {
    int                due;
    logic [I_DATA-1:0] din;
    logic [I_DATA-1:0] dout;
  } exp_t;

  exp_t q[$];
  int   cyc;
  int   n_chk;
  int   n_fail;
  logic checking;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
    n_chk++;
    if (act !== ex) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, ex, cyc);
    end
  endtask

  // Reference: value = x / 2^R; find floor(log2 |x|), scale to I_MNT+1
  // significant bits with round-half-even, then bias the exponent.
  function automatic logic [I_DATA-1:0] model(input logic [I_DATA-1:0] x);
    longint v, m, q2, r2, dv;
    int     e, eb;
    logic   s;
    v = longint'($signed(x));
    if (v == 0) return '0;
    s = (v < 0);
    m = s ? -v : v;
    e = 0;
    while ((m >> (e + 1)) != 0) e++;
    if (e <= I_MNT) begin
      q2 = m << (I_MNT - e);
    end else begin
      dv = longint'(1) << (e - I_MNT);
      q2 = m / dv;
      r2 = m % dv;
      if ((2 * r2 > dv) || ((2 * r2 == dv) && (q2 % 2 == 1))) q2 = q2 + 1;
    end
    if (q2 == (longint'(1) << (I_MNT + 1))) begin
      q2 = q2 >> 1;
      e++;
    end
    eb = e - R + BIAS;
    if (eb <= 0) return {s, {(I_DATA-1){1'b0}}};
    if (eb >= (1 << I_EXP) - 1) return {s, {I_EXP{1'b1}}, {I_MNT{1'b0}}};
    return {s, eb[I_EXP-1:0], q2[I_MNT-1:0]};
  endfunction

  // FP word back to a fixed-point integer with R fractional bits.
  function automatic longint decode(input logic [I_DATA-1:0] f);
    int     eb, sh;
    longint sig, v;
    eb = int'(f[I_DATA-2 -: I_EXP]);
    if (eb == 0) return 0;
    sig = (longint'(1) << I_MNT) + longint'(f[I_MNT-1:0]);
    sh  = eb - BIAS + R - I_MNT;
    v   = (sh >= 0) ? (sig << sh) : (sig >> (-sh));
    return f[I_DATA-1] ? -v : v;
  endfunction

  function automatic int sig_bits(input logic [I_DATA-1:0] x);
    longint m;
    int     n;
    m = longint'($signed(x));
    if (m < 0) m = -m;
    if (m == 0) return 0;
    while (m % 2 == 0) m = m / 2;
    n = 0;
    while (m != 0) begin
      n++;
      m = m >> 1;
    end
    return n;
  endfunction

  function automatic logic [I_DATA-1:0] gen();
    logic [I_DATA-1:0] v;
    logic [10:0]       s11;
    v = '0;
    case ($urandom_range(0, 3))
      0: v = I_DATA'($urandom);
      1: begin
        s11 = 11'($urandom);
        v = I_DATA'(s11) << $urandom_range(0, 4);
        if ($urandom_range(0, 1) == 1) v = -v;
      end
      2: begin
        case ($urandom_range(0, 5))
          0: v = 16'h8000;
          1: v = 16'h7FFF;
          2: v = 16'h0001;
          3: v = 16'hFFFF;
          4: v = 16'h0000;
          default: v = 16'h8001;
        endcase
      end
      default: v = I_DATA'($urandom_range(0, 63));
    endcase
    return v;
  endfunction

  task automatic drive(input logic en, input logic [I_DATA-1:0] v, input logic [I_DATA-1:0] ex);
    @(negedge clk);
    enable = en;
    int_in = v;
    if (en) q.push_back('{due: cyc + 3, din: v, dout: ex});
  endtask

  // Compare process: every cycle, out_valid must be high exactly when a
  // sample is due, and then fp_out must match.
  initial begin
    exp_t   e;
    logic   exp_v;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      if (!reset) q.delete();
      #1;
      if (checking) begin
        exp_v = (q.size() != 0) && (q[0].due == cyc);
        chk("out_valid", 32'(out_valid), 32'(exp_v));
        if (!reset) chk("fp_out_in_reset", 32'(fp_out), 32'h0);
        if (exp_v) begin
          e = q.pop_front();
          chk("fp_out", 32'(fp_out), 32'(e.dout));
          if (sig_bits(e.din) <= I_MNT + 1)
            chk("roundtrip", 32'(decode(fp_out)), 32'(longint'($signed(e.din))));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  logic [I_DATA-1:0] dir_in  [8];
  logic [I_DATA-1:0] dir_out [8];

  initial begin
    logic [I_DATA-1:0] v;
    clk = 1'b0;
    reset = 1'b1;
    enable = 1'b0;
    int_in = '0;
    checking = 1'b0;
    cyc = 0;
    n_chk = 0;
    n_fail = 0;

    dir_in[0] = 16'h0100; dir_out[0] = 16'h3C00;
    dir_in[1] = 16'hFF00; dir_out[1] = 16'hBC00;
    dir_in[2] = 16'h0000; dir_out[2] = 16'h0000;
    dir_in[3] = 16'h0001; dir_out[3] = 16'h1C00;
    dir_in[4] = 16'h8000; dir_out[4] = 16'hD800;
    dir_in[5] = 16'h7FFF; dir_out[5] = 16'h5800;
    dir_in[6] = 16'h0801; dir_out[6] = 16'h4800;
    dir_in[7] = 16'h0803; dir_out[7] = 16'h4802;

    #2 reset = 1'b0;
    #1;
    chk("reset_fp_out", 32'(fp_out), 32'h0);
    chk("reset_out_valid", 32'(out_valid), 32'h0);
    checking = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 8; i++)
      chk("model_pin", 32'(model(dir_in[i])), 32'(dir_out[i]));

    for (int i = 0; i < 8; i++) drive(1'b1, dir_in[i], dir_out[i]);
    for (int i = 0; i < 8; i++) drive(1'b0, dir_in[i], '0);
    for (int i = 0; i < 8; i++) drive(1'b1, dir_in[i], dir_out[i]);
    drive(1'b0, '0, '0);

    for (int i = 0; i < 90; i++) begin
      v = gen();
      drive((i % 3) == 0, v, model(v));
    end

    // Four samples back to back, then reset while three are in flight.
    for (int i = 0; i < 4; i++) begin
      v = gen();
      drive(1'b1, v, model(v));
    end
    #2;
    chk("valid_before_reset", 32'(out_valid), 32'h1);
    reset = 1'b0;
    enable = 1'b0;
    #1;
    chk("midreset_fp_out", 32'(fp_out), 32'h0);
    chk("midreset_out_valid", 32'(out_valid), 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) drive(1'b0, 16'h1234, '0);

    for (int i = 0; i < 300; i++) begin
      v = gen();
      drive($urandom_range(0, 3) != 0, v, model(v));
    end
    repeat (6) drive(1'b0, '0, '0);
    chk("queue_drained", 32'(q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
